// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared widths, the per-stage record type and the bubble constructor
// used by the pipeline register chain and its fetch-side interface.
package pipeline_pkg;

   localparam int MC_W = 32;
   localparam int ID_W = 25;

   // All-zero microcode: reg write-enable and rs1/rs2 check bits are clear,
   // so a bubble can never look like a producer or consumer to the detector.
   localparam logic [MC_W-1:0] NOP_MICROCODE = '0;

   typedef struct packed {
      logic            valid;
      logic [MC_W-1:0] microcode;
      logic [ID_W-1:0] instruction_data;
   } stage_t;

   function automatic stage_t bubble();
      stage_t b;
      b.valid            = 1'b0;
      b.microcode        = NOP_MICROCODE;
      b.instruction_data = '0;
      return b;
   endfunction

endpackage

// File: rtl/pipeline_stage_regs_if.sv
// pipeline_stage_regs_if
// Fetch/decode to pipeline handshake.
//   in_valid            : fetch presents an instruction
//   in_ready            : pipeline accepts it this cycle (combinational)
//   in_microcode        : microcode of the presented instruction
//   in_instruction_data : instruction data of the presented instruction
interface pipeline_stage_regs_if;
   import pipeline_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [MC_W-1:0] in_microcode;
   logic [ID_W-1:0] in_instruction_data;

   modport master (output in_valid, output in_microcode,
                   output in_instruction_data, input in_ready);
   modport slave  (input in_valid, input in_microcode,
                   input in_instruction_data, output in_ready);

endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// One pipeline stage register holding a stage_t record.
//   clk, rst_n : clock, asynchronous active-low reset (clears to a bubble)
//   i_hold     : keep current contents (has priority over i_bubble)
//   i_bubble   : load a bubble instead of i_d
//   i_d        : next stage contents
//   o_q        : registered stage contents
module pipe_stage_reg
   import pipeline_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_hold,
   input  logic   i_bubble,
   input  stage_t i_d,
   output stage_t o_q
);

   stage_t r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= bubble();
      end else if (!i_hold) begin
         r_q <= i_bubble ? bubble() : i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// pipeline_stage_regs
// Four-stage (s0..s3) register chain for microcode and instruction data.
// Holds s0 and injects bubbles into s1 while the dependency detector flags
// a hazard on a valid s0, squashes s0/s1 on flush, and counts stall cycles.
//   clk, rst_n                : clock, asynchronous active-low reset
//   fetch (slave)             : in_valid/in_ready/in_microcode/in_instruction_data
//   data_dependency           : hazard flag for the current s0 contents
//   flush                     : redirect resolved in s1, kill younger entries
//   microcode_sN, instruction_data_sN, valid_sN : per-stage contents
//   stall_count               : saturating count of stall cycles
module pipeline_stage_regs #(
   parameter int MC_W  = pipeline_pkg::MC_W,
   parameter int ID_W  = pipeline_pkg::ID_W,
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_stage_regs_if.slave  fetch,
   input  logic                  data_dependency,
   input  logic                  flush,
   output logic [MC_W-1:0]       microcode_s0,
   output logic [MC_W-1:0]       microcode_s1,
   output logic [MC_W-1:0]       microcode_s2,
   output logic [MC_W-1:0]       microcode_s3,
   output logic [ID_W-1:0]       instruction_data_s0,
   output logic [ID_W-1:0]       instruction_data_s1,
   output logic [ID_W-1:0]       instruction_data_s2,
   output logic [ID_W-1:0]       instruction_data_s3,
   output logic                  valid_s0,
   output logic                  valid_s1,
   output logic                  valid_s2,
   output logic                  valid_s3,
   output logic [CNT_W-1:0]      stall_count
);
   import pipeline_pkg::*;

   stage_t           w_in;
   stage_t           w_p0, w_p1, w_p2, w_p3;
   logic             w_stall;
   logic [CNT_W-1:0] r_stall_cnt;

   // A bubble in s0 never stalls; flush overrides a pending hazard.
   assign w_stall        = data_dependency & w_p0.valid & ~flush;
   assign fetch.in_ready = ~w_stall;

   always_comb begin
      w_in                  = bubble();
      w_in.valid            = 1'b1;
      w_in.microcode        = fetch.in_microcode;
      w_in.instruction_data = fetch.in_instruction_data;
   end

   // s0: holds on stall; on flush the presented word is consumed and dropped
   pipe_stage_reg u_s0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (w_stall),
      .i_bubble (flush | ~fetch.in_valid),
      .i_d      (w_in),
      .o_q      (w_p0)
   );

   // s1: bubble while s0 is held or when the younger entry is squashed
   pipe_stage_reg u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (1'b0),
      .i_bubble (flush | w_stall),
      .i_d      (w_p0),
      .o_q      (w_p1)
   );

   // s2: the s1 entry (e.g. the branch) always proceeds
   pipe_stage_reg u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (1'b0),
      .i_bubble (1'b0),
      .i_d      (w_p1),
      .o_q      (w_p2)
   );

   // s3: last stage; its old contents fall off toward writeback
   pipe_stage_reg u_s3 (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_hold   (1'b0),
      .i_bubble (1'b0),
      .i_d      (w_p2),
      .o_q      (w_p3)
   );

   // Stall counter saturates at all-ones rather than wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_count = r_stall_cnt;

   assign valid_s0            = w_p0.valid;
   assign valid_s1            = w_p1.valid;
   assign valid_s2            = w_p2.valid;
   assign valid_s3            = w_p3.valid;
   assign microcode_s0        = w_p0.microcode;
   assign microcode_s1        = w_p1.microcode;
   assign microcode_s2        = w_p2.microcode;
   assign microcode_s3        = w_p3.microcode;
   assign instruction_data_s0 = w_p0.instruction_data;
   assign instruction_data_s1 = w_p1.instruction_data;
   assign instruction_data_s2 = w_p2.instruction_data;
   assign instruction_data_s3 = w_p3.instruction_data;

endmodule

// File: doc/pipeline_stage_regs.md
# pipeline_stage_regs

Four-stage pipeline register chain holding microcode and instruction data for stages s0–s3. It feeds the data-dependency detector and acts on its `data_dependency` result. When a hazard is flagged it holds s0, applies back-pressure to fetch and injects a bubble into s1 until the hazard retires. It also squashes wrong-path instructions on `flush` and keeps a saturating stall-cycle counter for performance visibility.

## Interface
Parameters:
- `MC_W`, 32: microcode width.
- `ID_W`, 25: instruction-data width.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch/decode presents a new instruction.
- `in_ready` output 1: stage accepts the instruction this cycle (combinational).
- `in_microcode` input MC_W: microcode of the incoming instruction.
- `in_instruction_data` input ID_W: instruction data of the incoming instruction.
- `data_dependency` input 1: hazard flag for the current s0 contents, computed combinationally from this block's outputs.
- `flush` input 1: branch/jump redirect resolved in s1; kill the younger instructions.
- `microcode_s0..s3` output MC_W each: per-stage microcode.
- `instruction_data_s0..s3` output ID_W each: per-stage instruction data.
- `valid_s0..s3` output 1 each: stage holds a real instruction.
- `stall_count` output CNT_W: saturating count of stall cycles.

Clock and reset are decided: one clock, `clk`; reset `rst_n` is asynchronous and active-low.

## Operation
- Bubble: microcode = `NOP_MICROCODE` (all zero, so reg write-enable and the rs1/rs2 check bits are 0), instruction data = 0, valid = 0.
- `stall = data_dependency & valid_s0 & ~flush`.
- Priority: flush > stall > advance. Exactly one of the following applies per cycle:
  - **Flush.** s3<=s2 and s2<=s1, since the branch in s1 proceeds. s1 and s0 load bubbles. The input is consumed and discarded: `in_ready`=1 and nothing is captured. `stall_count` does not increment.
  - **Stall.** s0 holds. s1 loads a bubble. s3<=s2 and s2<=s1. `in_ready`=0. `stall_count` increments, saturating at all-ones (no wrap).
  - **Advance.** s3<=s2, s2<=s1, s1<=s0. s0 loads the input if `in_valid`, otherwise a bubble. `in_ready`=1.
- `data_dependency` is ignored when `valid_s0`=0; a bubble never stalls.
- On each advance, s3 contents fall off the end. Writeback happens downstream of s3 and is not this block's concern.
- Control states: RUN (no stall) and STALL. These are implicit in `stall` and need no explicit FSM register. STALL exits on the first cycle `data_dependency` drops, or on `flush`.

## Timing
- Every stage output is registered. Only `in_ready` is combinational, from `data_dependency`, `valid_s0` and `flush`.
- Latency: an accepted instruction appears in s0 one edge after the handshake (`in_valid & in_ready`) and reaches s3 three edges after that, absent stalls.
- Stall duration equals the number of cycles the detector asserts. For a producer in s1 that is at most 3 cycles. Each stalled cycle adds exactly one bubble into s1.
- Reset (async assert, sync release in the clk domain):
  - all stage microcode and instruction data = 0;
  - all valid = 0;
  - `stall_count` = 0;
  - `in_ready` = 1 (because `valid_s0`=0).
- Reset mid-stall: all stages clear immediately. The held instruction is lost; fetch re-issues it.
- Flush and dependency in the same cycle: flush wins; s0 is killed, not held.
- `in_valid`=0 while stalled has no effect. `in_valid`=1 with `in_ready`=0: upstream must hold its data stable.

## Structure
- Package `pipeline_pkg`:
  - `MC_W`, `ID_W`, `NOP_MICROCODE`;
  - typedef `stage_t` struct {valid, microcode, instruction_data};
  - function `bubble()` returning a NOP `stage_t`.
- Sub-module `pipe_stage_reg`: one `stage_t` register with async reset, a hold enable, and a bubble-insert select. Instantiated four times; the top level holds the stall/flush logic and the counter.

## Test plan
- Reset, then 4 back-to-back instructions A–D with no hazard → A reaches s3 on the 4th edge after acceptance; `in_ready` is constantly 1; `stall_count`=0.
- A writes x5; B reads x5 in the following cycle, with `data_dependency` held for 3 cycles → B stays in s0 for 3 cycles; three bubbles enter s1 (`valid_s1`=0); `in_ready`=0 for 3 cycles; `stall_count`=3.
- `data_dependency`=1 while `valid_s0`=0 → no stall; `in_ready`=1; counter unchanged.
- `flush` with s0=C, s1=branch, `in_valid`=1 (word E) → next edge: s2=branch, s1 and s0 are bubbles, E is dropped.
- `flush` and `data_dependency` asserted together → flush behaviour only; `stall_count` unchanged.
- Preload `stall_count` to 0xFFFE, then stall 3 cycles → saturates at 0xFFFF. Separately, assert `rst_n`=0 mid-stall → all valid=0 and `stall_count`=0 asynchronously, before the next clock edge.
